// File: rtl/imm_pkg.sv
// Shared decode-stage types: immediate format select and base opcode constants.
// No timing: types and constants only.
// No flow control: consumed by imm_decode, imm_gen_pipe and the control unit.
package imm_pkg;

    // Immediate format select driven by the control unit.
    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_U   = 3'b001,
        IMM_S   = 3'b010,
        IMM_B   = 3'b011,
        IMM_J   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_BAD = 3'b111
    } imm_src_e;

    // Base opcodes the control unit maps onto an imm_src_e.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 values that pick the shift-immediate and CSR-immediate forms.
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// Extracts and extends a RISC-V immediate from a raw instruction word.
// Latency: purely combinational, zero cycles.
// No flow control: caller qualifies the result with its own valid.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_src_e        imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Opcode bits carry no immediate payload in any format.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    logic [31:0] sx_val;
    logic [31:0] zx_val;
    logic        sext;

    // Assemble the 32-bit form, then widen by sign or zero extension.
    always_comb begin
        sx_val = '0;
        zx_val = '0;
        sext   = 1'b1;
        err    = 1'b0;
        case (imm_src)
            IMM_I:  sx_val = {{20{instr[31]}}, instr[31:20]};
            IMM_U:  sx_val = {instr[31:12], 12'b0};
            IMM_S:  sx_val = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:  sx_val = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_J:  sx_val = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            IMM_Z: begin
                sext   = 1'b0;
                zx_val = {27'b0, instr[19:15]};
            end
            IMM_SH: begin
                // RV64 shifts carry a 6-bit shamt, RV32 only 5 bits.
                sext   = 1'b0;
                zx_val = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            end
            default: err = 1'b1;
        endcase
        imm = sext ? XLEN'($signed(sx_val)) : XLEN'(zx_val);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry skid buffer carrying imm, err flag and sideband tag.
// Latency: one cycle from input handshake to out_valid.
// Backpressure: in_ready depends only on registered occupancy; full throughput while out_ready=1.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm_src (imm_src_e'(imm_src)),
        .imm     (dec_imm),
        .err     (dec_err)
    );

    // Buffer holds the decoded result only; the raw instruction is never kept.
    logic [1:0][XLEN-1:0]  imm_q;
    logic [1:0]            err_q;
    logic [1:0][TAG_W-1:0] tag_q;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count != 2'd2) & ~rst;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_imm = imm_q[rd_ptr];
    assign out_err = err_q[rd_ptr];
    assign out_tag = tag_q[rd_ptr];

    // Occupancy, pointers and storage; reset clears everything, flush only empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q  <= '0;
            err_q  <= '0;
            tag_q  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                imm_q[wr_ptr] <= dec_imm;
                err_q[wr_ptr] <= dec_err;
                tag_q[wr_ptr] <= in_tag;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
